mov_avr_mc: RTL and testbench
=============================

# mov_avr_mc

Parametrised, multi-channel moving-average filter: the next generation of the single-channel, fixed-window `MovAvr`. It keeps a per-channel running sum over a power-of-two window of DEPTH = 2^LOG2_DEPTH samples and produces one averaged sample per accepted input. Samples from up to CHANNELS interleaved streams arrive tagged with a channel id and are accepted back-to-back at one per cycle. It sits between a sampling front-end and downstream decision logic.

## Interface
- DATA_W, 8: sample and average width.
- LOG2_DEPTH, 3: window depth exponent; legal range 0..8.
- CHANNELS, 4: number of independent channels, 1..16. CH_W = max(1, $clog2(CHANNELS)).
- SIGNED, 0: 0 = unsigned samples; 1 = two's-complement samples.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; while low, inputs are ignored.
- clr  in  1  synchronous clear of all channel state.
- in_valid  in  1  sample present.
- in_ch  in  CH_W  channel id of the sample.
- in_data  in  DATA_W  sample value.
- out_valid  out  1  averaged result valid; pulses for one cycle per accepted sample.
- out_ch  out  CH_W  channel of the result.
- out_avg  out  DATA_W  window average.
- out_full  out  1  the channel's window was completely populated when this result was produced.

## Operation
- **Accept condition:** `en && in_valid && !clr && in_ch < CHANNELS`. Samples with an out-of-range channel id are dropped silently and produce no `out_valid`.
- **Per-channel state:**
  - ring of DEPTH samples, zero-initialised;
  - write pointer `wp` (LOG2_DEPTH bits);
  - fill count (0..DEPTH, saturating);
  - running sum of SUM_W = DATA_W + LOG2_DEPTH bits, signed when SIGNED=1.
- **On accept, for channel c:**
  - oldest = ring[c][wp[c]];
  - sum[c] ← sum[c] − oldest + in_data, with sign extension when SIGNED=1;
  - ring[c][wp[c]] ← in_data;
  - wp[c] increments and wraps from DEPTH−1 to 0;
  - fill[c] increments and saturates at DEPTH.
- **Average:** new sum shifted right by LOG2_DEPTH (arithmetic shift when SIGNED=1), keeping the low DATA_W bits.
  - The result is always in range; no saturation logic is required.
  - LOG2_DEPTH=0 passes samples straight through.
- **Warm-up:** before the window fills, zeros stand in for missing samples, so the average is diluted (sum/DEPTH). `out_full` is 0 until fill reaches DEPTH.
- **Back-to-back same-channel samples:** each sample sees the sum already updated by the previous one. There are no hazards or stalls, and every cycle may carry a sample.
- **clr:**
  - zeroes all rings, sums, pointers and fill counts at the next edge;
  - drops any sample presented in the same cycle;
  - drives `out_valid` to 0 on the next cycle.
- **en low:** no state changes; `out_valid` is 0 on the next cycle; `out_avg`, `out_ch` and `out_full` hold their values.

## Timing
- Latency is 1 cycle: a sample accepted at edge k yields `out_valid`, `out_ch`, `out_avg` and `out_full` valid after edge k.
- Throughput is 1 sample per cycle, across any mix of channels.
- `out_avg`, `out_ch` and `out_full` update only on accept.
- Reset (asynchronous, at any time, including mid-stream):
  - `out_valid`=0, `out_ch`=0, `out_avg`=0, `out_full`=0;
  - all rings, sums, pointers and fill counts = 0.
- Precedence: rst > clr > accept.

## Configuration
- `MOV_AVR_ROUND_EN` defined: a rounding constant of 2^(LOG2_DEPTH−1) is added to the sum before the shift, computed at SUM_W+1 bits, giving round-half-up (toward +inf). With LOG2_DEPTH=0 there is no effect.
- Not defined: the shift truncates, giving floor toward −inf.

## Structure
- **Package `mov_avr_pkg`:**
  - `sum_t` width function;
  - `round_const` function;
  - CH_W derivation;
  - shared localparams DEPTH and SUM_W.
- **Sub-module `mov_avr_ring`:**
  - DEPTH×DATA_W circular store for one channel with its `wp` and fill count;
  - reports the oldest sample;
  - instantiated CHANNELS times via generate.
- **Top level:** channel mux, sum registers, divider/rounder and output registers.

## Test plan
1. **Unsigned warm-up and steady state.** DATA_W=8, LOG2_DEPTH=3, ch0, value 80 each cycle for 8 cycles.
   - Expect `out_avg` = 10, 20, …, 80.
   - `out_full` rises on the 8th result.
   - A 9th sample of 0 gives 70.
2. **Interleaved channels.** ch0=16 and ch1=240 alternating for 16 cycles.
   - Each channel's result is independent; final results are 16 and 240, each with `out_full`=1.
3. **Signed mode.** SIGNED=1, ch2, eight samples of −3.
   - Without the macro, warm-up results are floor(−3k/8); the final result is −3.
   - With `MOV_AVR_ROUND_EN`, the first result is round(−3/8) = 0 and the final result is −3.
4. **clr mid-stream.** Assert `clr` after 5 samples of 64 on ch0, with a sample presented in the same cycle.
   - No `out_valid` the next cycle.
   - The next sample of 64 yields 8 with `out_full`=0.
5. **Async rst mid-stream.** Assert `rst` between clock edges while `out_valid`=1.
   - All outputs go to 0 immediately.
   - After release, the first sample of 8 on ch0 yields 1.
6. **Gating.**
   - `en`=0 with `in_valid`=1 for 3 cycles: no `out_valid`, and `out_avg` holds.
   - With CHANNELS=3, `in_ch`=3 is dropped with no state change.

Source files
------------

// File: rtl/mov_avr_pkg.sv
// mov_avr_pkg: shared definitions for the multi-channel moving-average filter.
//   ch_w()        : channel-id width, max(1, clog2(channels))
//   sum_w()       : running-sum width, data width plus window exponent
//   round_const() : half-LSB of the post-shift result, 2^(log2_depth-1) or 0
//   DEPTH / SUM_W : window depth and sum width of the default configuration
//   sum_t         : running-sum type of the default configuration
// Optional feature macro used by the filter: MOV_AVR_ROUND_EN.
package mov_avr_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_LOG2_DEPTH = 3;
    localparam int DEPTH          = 1 << DEF_LOG2_DEPTH;
    localparam int SUM_W          = DEF_DATA_W + DEF_LOG2_DEPTH;

    typedef logic [SUM_W-1:0] sum_t;

    function automatic int ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int sum_w(input int data_w, input int log2_depth);
        return data_w + log2_depth;
    endfunction

    function automatic int round_const(input int log2_depth);
        return (log2_depth == 0) ? 0 : (1 << (log2_depth - 1));
    endfunction

endpackage

// File: rtl/mov_avr_ring.sv
// mov_avr_ring: circular sample store for one channel of the moving-average filter.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clr_i          synchronous clear of samples, pointer and fill count
//   wr_i           write data_i over the oldest sample and advance
//   data_i         incoming sample
//   oldest_o       sample that the next write will overwrite
//   full_next_o    the window will be completely populated once the next write lands
module mov_avr_ring #(
    parameter int DATA_W     = 8,
    parameter int LOG2_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] oldest_o,
    output logic              full_next_o
);

    localparam int RING_D = 1 << LOG2_DEPTH;
    localparam int PTR_W  = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
    localparam int FILL_W = LOG2_DEPTH + 1;

    logic [DATA_W-1:0] mem_q [RING_D];
    logic [PTR_W-1:0]  wp_q, wp_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    always_comb begin
        wp_d        = (wp_q == PTR_W'(RING_D - 1)) ? '0 : wp_q + 1'b1;
        fill_d      = (fill_q == FILL_W'(RING_D)) ? fill_q : fill_q + 1'b1;
        // Already full, or exactly one sample short of full.
        full_next_o = (fill_q >= FILL_W'(RING_D - 1));
        oldest_o    = mem_q[wp_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RING_D; i++) mem_q[i] <= '0;
            wp_q   <= '0;
            fill_q <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < RING_D; i++) mem_q[i] <= '0;
            wp_q   <= '0;
            fill_q <= '0;
        end else if (wr_i) begin
            mem_q[wp_q] <= data_i;
            wp_q        <= wp_d;
            fill_q      <= fill_d;
        end
    end

endmodule

// File: rtl/mov_avr_mc.sv
// mov_avr_mc: multi-channel moving-average filter over a 2^LOG2_DEPTH window.
// One result per accepted sample, one cycle after acceptance; channels interleave freely.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   en           global enable; inputs ignored while low
//   clr          synchronous clear of all channel state
//   in_valid     sample present; in_ch channel id; in_data sample value
//   out_valid    one-cycle pulse per accepted sample
//   out_ch       channel of the result; out_avg window average
//   out_full     the channel's window was fully populated for this result
// Optional feature: define MOV_AVR_ROUND_EN for round-half-up instead of floor.
module mov_avr_mc
    import mov_avr_pkg::*;
#(
    parameter int  DATA_W     = 8,
    parameter int  LOG2_DEPTH = 3,
    parameter int  CHANNELS   = 4,
    parameter int  SIGNED     = 0,
    localparam int CH_W       = ch_w(CHANNELS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_avg,
    output logic              out_full
);

    localparam int L_SUM_W = sum_w(DATA_W, LOG2_DEPTH);

`ifdef MOV_AVR_ROUND_EN
    localparam logic [L_SUM_W:0] RND = (L_SUM_W + 1)'(round_const(LOG2_DEPTH));
`else
    localparam logic [L_SUM_W:0] RND = '0;
`endif

    logic                accept;
    logic [CHANNELS-1:0] wr;
    logic [CHANNELS-1:0] full_next;
    logic [DATA_W-1:0]   oldest_all [CHANNELS];
    logic [L_SUM_W-1:0]  sum_q      [CHANNELS];

    logic [DATA_W-1:0]   oldest;
    logic [L_SUM_W-1:0]  sum_sel, old_ext, new_ext, sum_d;
    logic [L_SUM_W:0]    sum_x, rnd;
    logic                full_sel;
    logic [DATA_W-1:0]   avg_d;

    logic                out_valid_q;
    logic [CH_W-1:0]     out_ch_q;
    logic [DATA_W-1:0]   out_avg_q;
    logic                out_full_q;

    assign accept = en && in_valid && !clr && (int'(in_ch) < CHANNELS);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ring
        mov_avr_ring #(
            .DATA_W     (DATA_W),
            .LOG2_DEPTH (LOG2_DEPTH)
        ) u_ring (
            .clk         (clk),
            .rst         (rst),
            .clr_i       (clr),
            .wr_i        (wr[g]),
            .data_i      (in_data),
            .oldest_o    (oldest_all[g]),
            .full_next_o (full_next[g])
        );
    end

    always_comb begin
        wr       = '0;
        oldest   = '0;
        sum_sel  = '0;
        full_sel = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (in_ch == CH_W'(c)) begin
                wr[c]    = accept;
                oldest   = oldest_all[c];
                sum_sel  = sum_q[c];
                full_sel = full_next[c];
            end
        end

        if (SIGNED != 0) begin
            old_ext = L_SUM_W'($signed(oldest));
            new_ext = L_SUM_W'($signed(in_data));
        end else begin
            old_ext = L_SUM_W'(oldest);
            new_ext = L_SUM_W'(in_data);
        end

        // The true window sum always fits SUM_W bits, so wraparound in the
        // intermediate subtraction cancels out.
        sum_d = sum_sel - old_ext + new_ext;

        // One extra bit so the rounding constant cannot overflow the sum.
        sum_x = (SIGNED != 0) ? {sum_d[L_SUM_W-1], sum_d} : {1'b0, sum_d};
        rnd   = sum_x + RND;

        if (SIGNED != 0) avg_d = DATA_W'($signed(rnd) >>> LOG2_DEPTH);
        else             avg_d = DATA_W'(rnd >> LOG2_DEPTH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) sum_q[c] <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_avg_q   <= '0;
            out_full_q  <= 1'b0;
        end else begin
            // accept is already false under clr or en low.
            out_valid_q <= accept;
            if (clr) begin
                for (int c = 0; c < CHANNELS; c++) sum_q[c] <= '0;
            end else if (accept) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (wr[c]) sum_q[c] <= sum_d;
                end
                out_ch_q   <= in_ch;
                out_avg_q  <= avg_d;
                out_full_q <= full_sel;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_avg   = out_avg_q;
    assign out_full  = out_full_q;

endmodule

// File: tb/tb_mov_avr_mc.sv
// tb_mov_avr_mc: directed bench for mov_avr_mc.
// dut_u: unsigned, 3 channels; dut_s: signed, 4 channels. Both share the inputs.
module tb_mov_avr_mc;

    localparam int W = 9;  // {full, avg}

    logic       clk = 1'b0;
    logic       rst, en, clr, in_valid;
    logic [1:0] in_ch;
    logic [7:0] in_data;

    logic       u_valid, u_full, s_valid, s_full;
    logic [1:0] u_ch, s_ch;
    logic [7:0] u_avg, s_avg;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   s_exp [8];

    always #5 clk = ~clk;

    mov_avr_mc #(.DATA_W(8), .LOG2_DEPTH(3), .CHANNELS(3), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
        .out_valid(u_valid), .out_ch(u_ch), .out_avg(u_avg), .out_full(u_full)
    );

    mov_avr_mc #(.DATA_W(8), .LOG2_DEPTH(3), .CHANNELS(4), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
        .out_valid(s_valid), .out_ch(s_ch), .out_avg(s_avg), .out_full(s_full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample, advance one edge, compare against the scoreboard entry.
    task automatic send(input string tag, input logic [1:0] ch, input logic [7:0] d,
                        input logic [7:0] exp_avg, input logic exp_full, input bit use_s);
        logic [W-1:0] e;
        en       = 1'b1;
        clr      = 1'b0;
        in_valid = 1'b1;
        in_ch    = ch;
        in_data  = d;
        exp_q.push_back({exp_full, exp_avg});
        tick();
        in_valid = 1'b0;
        e = exp_q.pop_front();
        if (use_s) begin
            check({tag, "_valid"}, 32'(s_valid), 32'd1);
            check({tag, "_ch"},    32'(s_ch),    32'(ch));
            check({tag, "_avg"},   32'(s_avg),   32'(e[7:0]));
            check({tag, "_full"},  32'(s_full),  32'(e[8]));
        end else begin
            check({tag, "_valid"}, 32'(u_valid), 32'd1);
            check({tag, "_ch"},    32'(u_ch),    32'(ch));
            check({tag, "_avg"},   32'(u_avg),   32'(e[7:0]));
            check({tag, "_full"},  32'(u_full),  32'(e[8]));
        end
    endtask

    task automatic clear_cycle();
        en       = 1'b1;
        clr      = 1'b1;
        in_valid = 1'b0;
        tick();
        clr = 1'b0;
        check("clr_valid", 32'(u_valid), 32'd0);
    endtask

    initial begin
`ifdef MOV_AVR_ROUND_EN
        s_exp = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFD, 8'hFD};
`else
        s_exp = '{8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFD, 8'hFD, 8'hFD};
`endif
        rst = 1'b1; en = 1'b0; clr = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0;

        // Reset state
        #12;
        check("rst_u_valid", 32'(u_valid), 32'd0);
        check("rst_u_avg",   32'(u_avg),   32'd0);
        check("rst_u_full",  32'(u_full),  32'd0);
        check("rst_s_valid", 32'(s_valid), 32'd0);
        rst = 1'b0;

        // 1: unsigned warm-up and steady state
        for (int k = 1; k <= 8; k++) send("t1", 2'd0, 8'd80, 8'(10 * k), (k == 8), 1'b0);
        send("t1_drop", 2'd0, 8'd0, 8'd70, 1'b1, 1'b0);
        tick();
        check("t1_idle_valid", 32'(u_valid), 32'd0);

        // 2: interleaved channels
        clear_cycle();
        for (int k = 1; k <= 8; k++) begin
            send("t2_c0", 2'd0, 8'd16,  8'(2 * k),  (k == 8), 1'b0);
            send("t2_c1", 2'd1, 8'd240, 8'(30 * k), (k == 8), 1'b0);
        end

        // 3: signed mode on ch2, eight samples of -3
        for (int k = 0; k < 8; k++) send("t3", 2'd2, 8'hFD, s_exp[k], (k == 7), 1'b1);

        // 4: clr mid-stream with a sample in the same cycle
        clear_cycle();
        for (int k = 1; k <= 5; k++) send("t4_pre", 2'd0, 8'd64, 8'(8 * k), 1'b0, 1'b0);
        clr = 1'b1; in_valid = 1'b1; in_ch = 2'd0; in_data = 8'd64;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        check("t4_clr_valid", 32'(u_valid), 32'd0);
        send("t4_post", 2'd0, 8'd64, 8'd8, 1'b0, 1'b0);

        // 5: asynchronous reset while out_valid is high
        send("t5_pre", 2'd1, 8'd240, 8'd30, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_valid", 32'(u_valid), 32'd0);
        check("t5_ch",    32'(u_ch),    32'd0);
        check("t5_avg",   32'(u_avg),   32'd0);
        check("t5_full",  32'(u_full),  32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        send("t5_post", 2'd0, 8'd8, 8'd1, 1'b0, 1'b0);

        // 6: gating by en and by out-of-range channel
        send("t6_pre", 2'd0, 8'd16, 8'd3, 1'b0, 1'b0);
        en = 1'b0; in_valid = 1'b1; in_ch = 2'd0; in_data = 8'd200;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_en_valid", 32'(u_valid), 32'd0);
            check("t6_en_avg",   32'(u_avg),   32'd3);
        end
        en = 1'b1; in_ch = 2'd3;
        tick();
        in_valid = 1'b0;
        check("t6_ch3_valid", 32'(u_valid), 32'd0);
        check("t6_ch3_avg",   32'(u_avg),   32'd3);
        check("t6_ch3_ch",    32'(u_ch),    32'd0);
        send("t6_post", 2'd0, 8'd0, 8'd3, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
